sobel_window_feeder: RTL and testbench
======================================

# sobel_window_feeder

Streaming front end for the `sobel` core. It accepts a raster-order 8-bit pixel stream and builds 3x3 neighbourhoods in two line buffers. It presents each complete window on the core's nine `data_i_*` inputs with `en_i` held high, and waits for `sonuc_done`. It then captures `data_o` as a result and drops enable so the core returns to idle before the next window.

## Interface
- IMG_W, 8, pixels per row; legal range 3..1024.
- IMG_H, 8, rows per frame; legal range 3..1024.
- TIMEOUT, 255, maximum cycles in FIRE before the window is abandoned; legal range ≥ 80.
- clk_i_s  in  1  clock; all logic on the rising edge.
- rst_n_i_s  in  1  reset, asynchronous and active-low.
- pix_i  in  8  input pixel, raster order (row 0 col 0 first).
- pix_valid_i  in  1  pix_i valid.
- pix_ready_o  out  1  feeder accepts a pixel this cycle.
- win_o_0 .. win_o_8  out  8 each  window taps, row-major.
  - win_o_0 = (r-2, c-2), win_o_4 = (r-1, c-1), win_o_8 = (r, c).
  - Connect to the core's data_i_0..data_i_8.
- win_en_o  out  1  drives the core's en_i.
- done_i  in  1  core's sonuc_done.
- res_i  in  9  core's data_o.
- res_o  out  8  captured result for the window.
- res_valid_o  out  1  one-cycle pulse, res_o valid.
- frame_done_o  out  1  one-cycle pulse when the last window of the frame exits FIRE.
- err_o  out  1  sticky timeout flag; cleared only by reset.

## Operation
- State FILL:
  - pix_ready_o=1; a pixel is accepted when pix_valid_i & pix_ready_o.
  - Accepting pixel p at (r, c):
    - top = lb1[c], mid = lb0[c].
    - lb1[c] <= lb0[c], lb0[c] <= p.
    - Window columns shift left: col0 <= col1, col1 <= col2.
    - New col2 = {top, mid, p}.
  - col increments; at col = IMG_W-1 it wraps to 0 and row increments.
  - At row = IMG_H-1 with col = IMG_W-1, both counters wrap to 0.
  - If the accepted pixel has r ≥ 2 and c ≥ 2, go to FIRE; otherwise stay in FILL.
- State FIRE:
  - pix_ready_o=0; win_en_o=1; win_o_* held constant.
  - Watchdog counter starts at 0 and increments each cycle.
  - done_i=1 sampled:
    - res_o <= (res_i[8] ? 8'd255 : res_i[7:0]); res_valid_o <= 1.
    - win_en_o <= 0; go to FILL.
  - Watchdog reaches TIMEOUT-1 without done_i:
    - win_en_o <= 0; err_o <= 1; no res_valid_o; go to FILL.
  - frame_done_o pulses on FIRE exit (done or timeout) when the window was (IMG_H-1, IMG_W-1).
- Windows per frame = (IMG_W-2)·(IMG_H-2). No border windows are generated.
- done_i is ignored outside FIRE.
- Line buffers are not reset. Stale contents never reach a fired window, because firing requires r ≥ 2.

## Timing
- Reset (rst_n_i_s=0, asynchronous):
  - State FILL; row, col and watchdog = 0.
  - win_o_* = 0, win_en_o = 0, res_o = 0, res_valid_o = 0, frame_done_o = 0, err_o = 0.
  - pix_ready_o = 0 while reset is asserted; 1 from the first edge after release.
- Accept on edge k of a qualifying pixel: win_o_* updated and win_en_o=1 from edge k; pix_ready_o=0 from edge k.
- done_i=1 sampled at edge m:
  - res_valid_o=1, win_en_o=0, pix_ready_o=1 for the cycle after m.
  - The core sees en_i=0 at edge m+1, so it stays idle and does not restart on the same window.
- Throughput is one pixel per cycle in FILL. FIRE blocks input for the core latency (about 70 cycles).
- Reset mid-FIRE: win_en_o falls asynchronously, the window is dropped, and the frame restarts at (0, 0).
- Watchdog width is clog2(TIMEOUT+1).

## Test plan
- Ramp, IMG_W=4, IMG_H=3, pix=0..11, done_i returned 70 cycles after each win_en_o rise:
  - First FIRE after pixel 10 with win = 0,1,2,4,5,6,8,9,10.
  - Second FIRE after pixel 11 with win = 1,2,3,5,6,7,9,10,11.
  - frame_done_o pulses once, with the second res_valid_o.
- Back-pressure, same ramp with pix_valid_i high continuously:
  - pix_ready_o=0 for the whole of each FIRE; no pixel lost or duplicated.
  - Second window still matches the values above.
- Result capture, res_i=9'h1FF at done_i → res_o=255; res_i=9'h07B → res_o=123; each res_valid_o pulse is exactly 1 cycle.
- Timeout, TIMEOUT=100, done_i held 0:
  - win_en_o falls after 100 FIRE cycles; err_o=1 and stays set.
  - No res_valid_o; the next window still fires normally.
- Reset mid-FIRE, assert rst_n_i_s=0 40 cycles into the first FIRE:
  - All outputs 0 immediately.
  - Restarting the ramp reproduces the first-scenario windows exactly.
- Full sobel integration, 8x8 frame with a vertical edge (cols 0-3 = 0, cols 4-7 = 200):
  - 36 res_valid_o pulses.
  - Result = 255 for windows centred at cols 3 and 4 (window c = 4, 5); result = 0 elsewhere.

Source files
------------

// File: rtl/sobel_window_feeder.sv
// Raster pixel stream to 3x3 window feeder for the sobel core.
// Two line buffers plus a column shift register build each window.
`timescale 1ns/1ps
module sobel_window_feeder #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic       clk_i_s,
  input  logic       rst_n_i_s,
  input  logic [7:0] pix_i,
  input  logic       pix_valid_i,
  output logic       pix_ready_o,
  output logic [7:0] win_o_0,
  output logic [7:0] win_o_1,
  output logic [7:0] win_o_2,
  output logic [7:0] win_o_3,
  output logic [7:0] win_o_4,
  output logic [7:0] win_o_5,
  output logic [7:0] win_o_6,
  output logic [7:0] win_o_7,
  output logic [7:0] win_o_8,
  output logic       win_en_o,
  input  logic       done_i,
  input  logic [8:0] res_i,
  output logic [7:0] res_o,
  output logic       res_valid_o,
  output logic       frame_done_o,
  output logic       err_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic {FILL, FIRE} state_t;

  state_t state, state_nx;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [WW-1:0] wdog;
  logic [7:0]    lb0 [IMG_W];
  logic [7:0]    lb1 [IMG_W];
  // Each column is {top, mid, bottom}.
  logic [2:0][7:0] c0, c1, c2;
  logic          last;

  logic accept, col_end, row_end, qual, wd_end;
  logic fire_ok, fire_to;

  assign accept  = (state == FILL) & pix_valid_i & pix_ready_o;
  assign col_end = (col == CW'(IMG_W - 1));
  assign row_end = (row == RW'(IMG_H - 1));
  assign qual    = (row >= RW'(2)) && (col >= CW'(2));
  assign wd_end  = (wdog == WW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    fire_ok  = 1'b0;
    fire_to  = 1'b0;
    unique case (state)
      FILL: if (accept && qual) state_nx = FIRE;
      FIRE: begin
        if (done_i) begin
          fire_ok  = 1'b1;
          state_nx = FILL;
        end else if (wd_end) begin
          fire_to  = 1'b1;
          state_nx = FILL;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i_s or negedge rst_n_i_s) begin
    if (!rst_n_i_s) state <= FILL;
    else            state <= state_nx;
  end

  always_ff @(posedge clk_i_s or negedge rst_n_i_s) begin
    if (!rst_n_i_s) begin
      row          <= '0;
      col          <= '0;
      wdog         <= '0;
      c0           <= '0;
      c1           <= '0;
      c2           <= '0;
      last         <= 1'b0;
      pix_ready_o  <= 1'b0;
      win_en_o     <= 1'b0;
      res_o        <= '0;
      res_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      pix_ready_o  <= (state_nx == FILL);
      win_en_o     <= (state_nx == FIRE);
      res_valid_o  <= fire_ok;
      frame_done_o <= (fire_ok | fire_to) & last;
      if (fire_ok) res_o <= res_i[8] ? 8'hFF : res_i[7:0];
      if (fire_to) err_o <= 1'b1;
      if (state == FIRE) wdog <= wdog + 1'b1;
      else               wdog <= '0;
      if (accept) begin
        c0   <= c1;
        c1   <= c2;
        c2   <= {lb1[col], lb0[col], pix_i};
        last <= row_end & col_end;
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Line buffers hold pixel data only; never reset.
  always_ff @(posedge clk_i_s) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pix_i;
    end
  end

  assign win_o_0 = c0[2];
  assign win_o_1 = c1[2];
  assign win_o_2 = c2[2];
  assign win_o_3 = c0[1];
  assign win_o_4 = c1[1];
  assign win_o_5 = c2[1];
  assign win_o_6 = c0[0];
  assign win_o_7 = c1[0];
  assign win_o_8 = c2[0];

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Directed bench for sobel_window_feeder with a behavioural core stub.
// Windows and results are scoreboarded against an image model.
`timescale 1ns/1ps
module tb_sobel_window_feeder;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int TO  = 100;
  localparam int LAT = 70;
  localparam logic [71:0] WIN1 = 72'h00_01_02_04_05_06_08_09_0A;
  localparam logic [71:0] WIN2 = 72'h01_02_03_05_06_07_09_0A_0B;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pix = '0;
  logic       pv = 1'b0;
  logic       ready;
  logic [7:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
  logic       en;
  logic       done = 1'b0;
  logic [8:0] res = '0;
  logic [7:0] res_o;
  logic       rv, fd, err;
  logic [71:0] taps;

  assign taps = {w0, w1, w2, w3, w4, w5, w6, w7, w8};

  sobel_window_feeder #(.IMG_W(W), .IMG_H(H), .TIMEOUT(TO)) dut (
    .clk_i_s(clk), .rst_n_i_s(rst_n),
    .pix_i(pix), .pix_valid_i(pv), .pix_ready_o(ready),
    .win_o_0(w0), .win_o_1(w1), .win_o_2(w2),
    .win_o_3(w3), .win_o_4(w4), .win_o_5(w5),
    .win_o_6(w6), .win_o_7(w7), .win_o_8(w8),
    .win_en_o(en), .done_i(done), .res_i(res),
    .res_o(res_o), .res_valid_o(rv),
    .frame_done_o(fd), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [71:0] taps;
    logic        last;
  } win_t;

  win_t       win_q[$];
  logic [7:0] res_exp_q[$];
  logic [8:0] res_src_q[$];
  int errors = 0, checks = 0;
  int n_res = 0, n_fd = 0;
  bit hang = 1'b0;
  logic [7:0] img [H][W];
  int br = 0, bc = 0;

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sat(input logic [8:0] v);
    return (v > 9'd255) ? 8'd255 : v[7:0];
  endfunction

  // Core stub: answers LAT cycles after enable unless hung.
  int ccnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ccnt = 0;
      done = 1'b0;
    end else begin
      done = 1'b0;
      if (en && !hang) begin
        ccnt++;
        if (ccnt == LAT) begin
          if (res_src_q.size() > 0) res = res_src_q.pop_front();
          else res = 9'h055;
          done = 1'b1;
          res_exp_q.push_back(sat(res));
          ccnt = 0;
        end
      end else begin
        ccnt = 0;
      end
    end
  end

  bit   pen = 1'b0, prv = 1'b0;
  logic cur_last = 1'b0;
  win_t ew;
  logic [7:0] er;
  always @(negedge clk) begin
    if (!rst_n) begin
      pen = 1'b0;
      prv = 1'b0;
    end else begin
      if (en && !pen) begin
        if (win_q.size() == 0) chk("win_unexpected", 1, 0);
        else begin
          ew = win_q.pop_front();
          chk("win_taps", taps, ew.taps);
          cur_last = ew.last;
        end
      end
      if (en) chk("ready_in_fire", ready, 0);
      chk("frame_done", fd, pen && !en && cur_last);
      if (rv) begin
        n_res++;
        chk("rv_pulse", prv, 0);
        chk("rv_idle", {en, ready}, 2'b01);
        if (res_exp_q.size() == 0) chk("res_unexpected", 1, 0);
        else begin
          er = res_exp_q.pop_front();
          chk("res_o", res_o, er);
        end
      end
      if (fd) n_fd++;
      pen = en;
      prv = rv;
    end
  end

  task automatic send(input logic [7:0] p, input bit gap);
    int n = 0;
    win_t w;
    pix = p;
    pv  = 1'b1;
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("ready_timeout", 1, 0);
      return;
    end
    img[br][bc] = p;
    if (br >= 2 && bc >= 2) begin
      w.taps = {img[br-2][bc-2], img[br-2][bc-1], img[br-2][bc],
                img[br-1][bc-2], img[br-1][bc-1], img[br-1][bc],
                img[br][bc-2],   img[br][bc-1],   img[br][bc]};
      w.last = (br == H - 1) && (bc == W - 1);
      win_q.push_back(w);
    end
    if (bc == W - 1) begin
      bc = 0;
      br = (br == H - 1) ? 0 : br + 1;
    end else begin
      bc++;
    end
    @(negedge clk);
    if (gap) begin
      pv = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(!en && ready && win_q.size() == 0 &&
             res_exp_q.size() == 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("idle_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic ramp(input bit gap, input bit tmo);
    int n;
    for (int p = 0; p < 12; p++) begin
      if (tmo && p == 10) hang = 1'b1;
      send(p[7:0], gap);
      if (p == 10) chk("win_first", taps, WIN1);
      if (p == 11) chk("win_second", taps, WIN2);
      if (tmo && p == 10) begin
        pv = 1'b0;
        n = 0;
        while (en && n < 500) begin
          @(negedge clk);
          n++;
        end
        chk("fire_len", n, TO);
        chk("err_set", err, 1);
        hang = 1'b0;
      end
    end
    pv = 1'b0;
    wait_idle();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outs", {taps, en, res_o, rv, fd, err, ready}, 0);
    rst_n = 1'b1;
    #1 chk("ready_release", ready, 0);
    @(negedge clk);
    chk("ready_after_edge", ready, 1);

    res_src_q.push_back(9'h012);
    res_src_q.push_back(9'h0AB);
    ramp(1'b1, 1'b0);
    chk("ramp_res", n_res, 2);
    chk("ramp_fd", n_fd, 1);
    chk("ramp_err", err, 0);

    res_src_q.push_back(9'h1FF);
    res_src_q.push_back(9'h07B);
    ramp(1'b0, 1'b0);
    chk("bp_res", n_res, 4);
    chk("bp_fd", n_fd, 2);
    chk("bp_last_res", res_o, 8'd123);

    ramp(1'b0, 1'b1);
    chk("tmo_res", n_res, 5);
    chk("tmo_fd", n_fd, 3);
    chk("err_sticky", err, 1);

    for (int p = 0; p < 11; p++) send(p[7:0], 1'b0);
    pv = 1'b0;
    repeat (39) @(negedge clk);
    chk("fire_before_rst", en, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {taps, en, res_o, rv, fd, err, ready}, 0);
    br = 0;
    bc = 0;
    win_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_restart", ready, 1);
    ramp(1'b1, 1'b0);
    chk("rst_res", n_res, 7);
    chk("rst_fd", n_fd, 4);
    chk("rst_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
